// File: rtl/tdm_pkg.sv
// Shared types and constants for the receive-side TDM demultiplexer.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT,
        ACQ,
        LOCK
    } state_t;

    localparam int SLOT_W = 3;
    localparam int N_CH   = 8;

endpackage

// File: rtl/tdm_demux8.sv
// 1:8 TDM demultiplexer: tracks frame alignment from slot-0 sync marks
// and rebuilds eight single-bit channels into a registered parallel word.
module tdm_demux8 #(
    parameter int MAX_MISS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            din,
    input  logic            din_valid,
    input  logic            sync_in,
    output logic [8-1:0]    y,
    output logic            frame_valid,
    output logic            locked,
    output logic            sync_err
);
    import tdm_pkg::*;

    localparam logic [SLOT_W-1:0] SLOT_0   = '0;
    localparam logic [SLOT_W-1:0] SLOT_1   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_7   = SLOT_W'(N_CH - 1);
    localparam logic [2:0]        MISS_LIM = 3'(MAX_MISS);

    state_t              state;
    logic [SLOT_W-1:0]   slot;
    logic [2:0]          miss;
    logic [N_CH-2:0]     hold;
    logic [2:0]          miss_inc;
    logic                early_sync;

    assign miss_inc   = miss + 3'd1;
    assign early_sync = sync_in && (slot != SLOT_0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= HUNT;
            slot        <= SLOT_0;
            miss        <= 3'd0;
            hold        <= '0;
            y           <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                unique case (state)
                    HUNT: begin
                        if (sync_in) begin
                            hold[0] <= din;
                            slot    <= SLOT_1;
                            miss    <= 3'd0;
                            state   <= ACQ;
                        end
                    end
                    ACQ, LOCK: begin
                        // A mark off slot 0 restarts the frame on this beat
                        if (early_sync) begin
                            sync_err <= 1'b1;
                            hold[0]  <= din;
                            slot     <= SLOT_1;
                            miss     <= 3'd0;
                            locked   <= 1'b0;
                            state    <= ACQ;
                        end else if (slot == SLOT_0) begin
                            if (sync_in) begin
                                miss    <= 3'd0;
                                hold[0] <= din;
                                slot    <= SLOT_1;
                            end else if (miss_inc >= MISS_LIM) begin
                                sync_err <= 1'b1;
                                miss     <= 3'd0;
                                locked   <= 1'b0;
                                state    <= HUNT;
                            end else begin
                                miss    <= miss_inc;
                                hold[0] <= din;
                                slot    <= SLOT_1;
                            end
                        end else if (slot == SLOT_7) begin
                            y           <= {din, hold};
                            frame_valid <= 1'b1;
                            slot        <= SLOT_0;
                            if (state == ACQ) begin
                                miss   <= 3'd0;
                                locked <= 1'b1;
                                state  <= LOCK;
                            end
                        end else begin
                            hold[slot] <= din;
                            slot       <= slot + SLOT_1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomised and directed checks of tdm_demux8 against a frame-level model.
module tb_tdm_demux8;

    localparam int MM = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sync_in = 1'b0;
    logic [7:0] y;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    tdm_demux8 #(.MAX_MISS(MM)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .din_valid(din_valid),
        .sync_in(sync_in),
        .y(y),
        .frame_valid(frame_valid),
        .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // Frame-level model: pos < 0 means not aligned, else next slot index
    logic [7:0] exp_y = 8'h00;
    logic       exp_fv = 1'b0;
    logic       exp_lk = 1'b0;
    logic       exp_se = 1'b0;
    logic [7:0] fr = 8'h00;
    int         pos = -1;
    int         misses = 0;

    always @(posedge clk) begin
        exp_fv = 1'b0;
        exp_se = 1'b0;
        if (!rst_n) begin
            exp_y = 8'h00;
            exp_lk = 1'b0;
            pos = -1;
            misses = 0;
        end else if (din_valid) begin
            if (pos < 0) begin
                if (sync_in) begin
                    fr[0] = din;
                    pos = 1;
                end
            end else if (sync_in && pos != 0) begin
                exp_se = 1'b1;
                exp_lk = 1'b0;
                misses = 0;
                fr[0] = din;
                pos = 1;
            end else if (pos == 0 && !sync_in) begin
                misses = misses + 1;
                if (misses >= MM) begin
                    exp_se = 1'b1;
                    exp_lk = 1'b0;
                    misses = 0;
                    pos = -1;
                end else begin
                    fr[0] = din;
                    pos = 1;
                end
            end else begin
                if (pos == 0) misses = 0;
                fr[pos] = din;
                pos = pos + 1;
                if (pos == 8) begin
                    exp_y = fr;
                    exp_fv = 1'b1;
                    if (!exp_lk) misses = 0;
                    exp_lk = 1'b1;
                    pos = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            n_cmp++;
            if (y !== exp_y || frame_valid !== exp_fv ||
                locked !== exp_lk || sync_err !== exp_se) begin
                n_bad++;
                $display("FAIL model t=%0t got y=%h fv=%b lk=%b se=%b want y=%h fv=%b lk=%b se=%b",
                         $time, y, frame_valid, locked, sync_err,
                         exp_y, exp_fv, exp_lk, exp_se);
            end
        end
    end

    int cyc = 0;
    int fv_cnt = 0;
    int pulse_cyc[$];
    logic [7:0] pulse_y[$];

    always @(posedge clk) begin
        cyc++;
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            pulse_cyc.push_back(cyc);
            pulse_y.push_back(y);
        end
    end

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic beat(input logic d, input logic s);
        @(negedge clk);
        din = d;
        sync_in = s;
        din_valid = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        din = 1'b0;
        sync_in = 1'b0;
        din_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] f, input logic s0, input bit stall);
        for (int i = 0; i < 8; i++) begin
            beat(f[i], s0 && i == 0);
            if (stall && i < 7) settle();
        end
    endtask

    initial begin
        int n0;
        int tx;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        chk("rst_y", y, 8'h00);
        chk("rst_fv", {7'd0, frame_valid}, 8'd0);
        chk("rst_lk", {7'd0, locked}, 8'd0);
        chk("rst_se", {7'd0, sync_err}, 8'd0);
        rst_n = 1'b1;

        send(8'h4D, 1'b1, 1'b0);
        settle();
        chk("align_y", y, 8'h4D);
        chk("align_fv", {7'd0, frame_valid}, 8'd1);
        chk("align_lk", {7'd0, locked}, 8'd1);
        settle();
        chk("align_fv_drop", {7'd0, frame_valid}, 8'd0);

        n0 = fv_cnt;
        send(8'h4D, 1'b1, 1'b1);
        settle();
        chk("stall_y", y, 8'h4D);
        settle();
        settle();
        chk("stall_fv_once", 8'(fv_cnt - n0), 8'd1);

        beat(1'b1, 1'b1);
        beat(1'b0, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b0, 1'b1);
        settle();
        chk("early_se", {7'd0, sync_err}, 8'd1);
        chk("early_lk", {7'd0, locked}, 8'd0);
        chk("early_fv", {7'd0, frame_valid}, 8'd0);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] f;
            f = 8'hA6;
            beat(f[i], 1'b0);
        end
        settle();
        chk("early_y", y, 8'hA6);
        chk("early_fv2", {7'd0, frame_valid}, 8'd1);
        chk("early_lk2", {7'd0, locked}, 8'd1);

        beat(1'b0, 1'b0);
        settle();
        chk("fly_se", {7'd0, sync_err}, 8'd0);
        chk("fly_lk", {7'd0, locked}, 8'd1);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] f;
            f = 8'h3C;
            beat(f[i], 1'b0);
        end
        settle();
        chk("fly_y", y, 8'h3C);
        chk("fly_fv", {7'd0, frame_valid}, 8'd1);
        beat(1'b1, 1'b0);
        settle();
        chk("miss2_se", {7'd0, sync_err}, 8'd1);
        chk("miss2_lk", {7'd0, locked}, 8'd0);

        send(8'h5A, 1'b1, 1'b0);
        settle();
        chk("relock_y", y, 8'h5A);
        beat(1'b1, 1'b1);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        beat(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        din_valid = 1'b0;
        sync_in = 1'b0;
        @(negedge clk);
        chk("mid_rst_y", y, 8'h00);
        chk("mid_rst_fv", {7'd0, frame_valid}, 8'd0);
        chk("mid_rst_lk", {7'd0, locked}, 8'd0);
        rst_n = 1'b1;
        n0 = fv_cnt;
        send(8'hFF, 1'b0, 1'b0);
        send(8'hFF, 1'b0, 1'b0);
        settle();
        settle();
        chk("nosync_fv", 8'(fv_cnt - n0), 8'd0);
        chk("nosync_y", y, 8'h00);

        pulse_cyc.delete();
        pulse_y.delete();
        send(8'h96, 1'b1, 1'b0);
        send(8'h96, 1'b1, 1'b0);
        settle();
        settle();
        chk("fa_pulses", 8'(pulse_cyc.size()), 8'd2);
        if (pulse_cyc.size() == 2) begin
            chk("fa_y0", pulse_y[0], 8'h96);
            chk("fa_y1", pulse_y[1], 8'h96);
            chk("fa_gap", 8'(pulse_cyc[1] - pulse_cyc[0]), 8'd8);
        end

        tx = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 499) != 0);
            din_valid = ($urandom_range(0, 9) < 7);
            din = 1'($urandom);
            if (tx == 0)
                sync_in = ($urandom_range(0, 19) != 0);
            else
                sync_in = ($urandom_range(0, 59) == 0);
            if (din_valid) tx = (tx + 1) % 8;
        end
        settle();
        rst_n = 1'b1;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdm_demux8.md
# tdm_demux8

Receive-side 1:8 time-division demultiplexer, the far end of the team's 8:1 mux datapath. A transmitter serialises eight single-bit channels into one bit per beat and flags slot 0 with a sync mark. This block tracks frame alignment, rebuilds the eight channels into a registered parallel word, and reports lock and sync errors. It sits between the serial link and the parallel consumers, for example the sum/carry checkers.

## Interface
- MAX_MISS, default 1: consecutive missing sync marks at slot 0 tolerated while locked before dropping to HUNT; legal range 1..7.
- clk  input  1  sole clock; all logic on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- din  input  1  serial channel bit for the current slot.
- din_valid  input  1  beat qualifier; cycles with din_valid=0 change no state.
- sync_in  input  1  slot-0 marker; only meaningful when din_valid=1.
- y  output  8  last complete frame; y[k] is the channel-k bit; registered.
- frame_valid  output  1  one-cycle pulse when y is updated.
- locked  output  1  high while in LOCK.
- sync_err  output  1  one-cycle pulse on any alignment violation.

## Operation
- A beat is a cycle with din_valid=1. The slot counter is 3 bits, advances only on beats, and wraps from 7 to 0.
- The holding register is 7 bits and stores slots 0..6. The slot-7 bit goes directly into y.
- States:
  - HUNT: beats without sync_in are ignored. A beat with sync_in stores the bit as slot 0, sets slot to 1 and moves to ACQ.
  - ACQ: each beat stores din at hold[slot] and increments slot. On the slot-7 beat: y <= {din, hold[6:0]}, frame_valid pulses, slot becomes 0, miss count is cleared, and the state moves to LOCK.
  - LOCK: collection is the same as in ACQ, and each slot-7 beat updates y and pulses frame_valid.
    - A slot-0 beat with sync_in clears the miss count.
    - A slot-0 beat without sync_in increments the miss count.
      - If the miss count is below MAX_MISS (flywheel): the bit is accepted as slot 0 and collection continues.
      - If the miss count reaches MAX_MISS: sync_err pulses, the partial frame is discarded, and the state moves to HUNT with slot 0 and miss count 0.
- Early sync: in ACQ or LOCK, a beat with sync_in at slot≠0:
  - sync_err pulses and the partial frame is discarded.
  - The beat is treated as a new slot 0: bit stored, slot becomes 1, state becomes ACQ, locked drops, miss count clears.
- Priority: an early sync outranks everything else. In HUNT, sync_err never fires.
- y holds its value between frames. A discarded partial frame never reaches y.

## Timing
- Reset values: y=8'h00, frame_valid=0, locked=0, sync_err=0; state HUNT, slot 0, miss count 0, hold cleared.
- Reset mid-frame discards the partial frame. The first beat after rst_n rises is evaluated in HUNT.
- Latency: the slot-7 beat in cycle N produces the new y and frame_valid=1 in cycle N+1.
- frame_valid is high for exactly one cycle per completed frame, even if din_valid stays low afterwards.
- locked rises in the cycle after the first completed frame (together with the first frame_valid). It falls in the cycle after the beat that causes an early-sync or a MAX_MISS exit.
- sync_err is registered and appears in the cycle after the offending beat.
- Throughput: one frame per 8 beats. Back-to-back frames with din_valid held high give frame_valid every 8 cycles.
- Stall cycles (din_valid=0) may occur between any two beats, including between slot 7 and slot 0, with no effect on alignment.

## Structure
- Shared package tdm_pkg:
  - State enum: HUNT, ACQ, LOCK.
  - SLOT_W = 3.
  - N_CH = 8.
- Single module with no sub-module. The slot counter and the miss counter are inline registers.

## Test plan
- Reset then aligned stream: sync on the first beat, bits 1,0,1,1,0,0,1,0 for slots 0..7, din_valid high.
  - Required: y=8'h4D and frame_valid one cycle after the slot-7 beat; locked rises in the same cycle.
- Stalls: the same frame with din_valid=0 inserted between every beat.
  - Required: identical y=8'h4D; frame_valid fires exactly once.
- Early sync: sync_in on slot 4 while locked.
  - Required: sync_err pulse, locked=0, and no frame_valid for the discarded frame.
  - The next 7 beats complete a frame from the new slot 0; frame_valid then fires and locked returns.
- Flywheel with MAX_MISS=2: one missing sync while locked.
  - Required: no sync_err, frame_valid still fires, locked stays 1.
  - A second consecutive miss produces sync_err, locked=0 and a return to HUNT.
- Reset mid-frame: assert rst_n=0 after slot 3.
  - Required: y=8'h00, frame_valid=0, locked=0.
  - Beats without sync_in afterwards produce no output.
- Full-adder channels: drive slots 0..7 with sum pattern 0,1,1,0,1,0,0,1 over two frames.
  - Required: y=8'h96 on both frame_valid pulses, 8 cycles apart.
